// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the round-robin arbitrated ALU.
package alu_arbiter_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Operation mode encodings.
    localparam logic MODE_LOGIC = 1'b1;
    localparam logic MODE_ARITH = 1'b0;

    // Function select codes. Meaning per code (logic mode / arithmetic mode, c = carry_in):
    //  0: ~A          / A + c              8: ~A | B     / A + (A&B) + c
    //  1: ~(A|B)      / (A|B) + c          9: ~(A^B)     / A + B + c
    //  2: ~A & B      / (A|~B) + c        10: B          / (A|~B) + (A&B) + c
    //  3: 0           / -1 + c            11: A & B      / (A&B) - 1 + c
    //  4: ~(A&B)      / A + (A&~B) + c    12: all ones   / A + A + c
    //  5: ~B          / (A|B)+(A&~B) + c  13: A | ~B     / (A|B) + A + c
    //  6: A ^ B       / A - B - 1 + c     14: A | B      / (A|~B) + A + c
    //  7: A & ~B      / (A&~B) - 1 + c    15: A          / A - 1 + c
    // Arithmetic is done in 17 bits; bit 16 is the carry, or the borrow for the subtracting forms.
    localparam logic [3:0] SEL_0  = 4'd0;
    localparam logic [3:0] SEL_1  = 4'd1;
    localparam logic [3:0] SEL_2  = 4'd2;
    localparam logic [3:0] SEL_3  = 4'd3;
    localparam logic [3:0] SEL_4  = 4'd4;
    localparam logic [3:0] SEL_5  = 4'd5;
    localparam logic [3:0] SEL_6  = 4'd6;
    localparam logic [3:0] SEL_7  = 4'd7;
    localparam logic [3:0] SEL_8  = 4'd8;
    localparam logic [3:0] SEL_9  = 4'd9;
    localparam logic [3:0] SEL_10 = 4'd10;
    localparam logic [3:0] SEL_11 = 4'd11;
    localparam logic [3:0] SEL_12 = 4'd12;
    localparam logic [3:0] SEL_13 = 4'd13;
    localparam logic [3:0] SEL_14 = 4'd14;
    localparam logic [3:0] SEL_15 = 4'd15;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between the requesters and the arbitrated ALU.
// Handshake: a request i transfers in the cycle where req_valid[i] && req_ready[i];
// a response transfers in the cycle where rsp_valid && rsp_ready. A source may
// drop valid before it transfers; once rsp_valid is high, rsp_* stay stable until transfer.
interface alu_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [4*NUM_REQ-1:0]  req_select;
    logic [NUM_REQ-1:0]    req_mode;
    logic [NUM_REQ-1:0]    req_carry;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [15:0]           rsp_result;
    logic                  rsp_carry;

    modport master (
        output req_valid, req_a, req_b, req_select, req_mode, req_carry, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry
    );

    modport slave (
        input  req_valid, req_a, req_b, req_select, req_mode, req_carry, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry
    );
endinterface

// File: rtl/alu_arbiter_alu.sv
// 16-bit combinational ALU with logic and arithmetic modes (see select table in the package).
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  sel,
    input  logic        mode,
    input  logic        carry_in,
    output logic [15:0] result,
    output logic        carry_out
);
    logic [16:0] a17, b17, c17, and17, or17, orn17, andn17;
    logic [16:0] arith_res;
    logic [15:0] logic_res;

    assign a17    = {1'b0, a};
    assign b17    = {1'b0, b};
    assign c17    = {16'b0, carry_in};
    assign and17  = {1'b0, a & b};
    assign or17   = {1'b0, a | b};
    assign orn17  = {1'b0, a | ~b};
    assign andn17 = {1'b0, a & ~b};

    // Arithmetic functions, 17-bit wide so bit 16 carries the carry/borrow.
    always_comb begin
        arith_res = '0;
        case (sel)
            SEL_0:   arith_res = a17 + c17;
            SEL_1:   arith_res = or17 + c17;
            SEL_2:   arith_res = orn17 + c17;
            SEL_3:   arith_res = 17'h1FFFF + c17;
            SEL_4:   arith_res = a17 + andn17 + c17;
            SEL_5:   arith_res = or17 + andn17 + c17;
            SEL_6:   arith_res = a17 - b17 - 17'd1 + c17;
            SEL_7:   arith_res = andn17 - 17'd1 + c17;
            SEL_8:   arith_res = a17 + and17 + c17;
            SEL_9:   arith_res = a17 + b17 + c17;
            SEL_10:  arith_res = orn17 + and17 + c17;
            SEL_11:  arith_res = and17 - 17'd1 + c17;
            SEL_12:  arith_res = a17 + a17 + c17;
            SEL_13:  arith_res = or17 + a17 + c17;
            SEL_14:  arith_res = orn17 + a17 + c17;
            default: arith_res = a17 - 17'd1 + c17;
        endcase
    end

    // Bitwise logic functions; carry_in is ignored in this mode.
    always_comb begin
        logic_res = '0;
        case (sel)
            SEL_0:   logic_res = ~a;
            SEL_1:   logic_res = ~(a | b);
            SEL_2:   logic_res = ~a & b;
            SEL_3:   logic_res = 16'h0000;
            SEL_4:   logic_res = ~(a & b);
            SEL_5:   logic_res = ~b;
            SEL_6:   logic_res = a ^ b;
            SEL_7:   logic_res = a & ~b;
            SEL_8:   logic_res = ~a | b;
            SEL_9:   logic_res = ~(a ^ b);
            SEL_10:  logic_res = b;
            SEL_11:  logic_res = a & b;
            SEL_12:  logic_res = 16'hFFFF;
            SEL_13:  logic_res = a | ~b;
            SEL_14:  logic_res = a | b;
            default: logic_res = a;
        endcase
    end

    assign result    = (mode == MODE_LOGIC) ? logic_res : arith_res[15:0];
    assign carry_out = (mode == MODE_LOGIC) ? 1'b0 : arith_res[16];
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters: accept, execute, respond.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus,
    output state_t       dbg_state
);
    state_t          state, next_state;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] cand;
    logic            grant_found;
    logic            accept;

    logic [15:0]     op_a, op_b;
    logic [3:0]      op_sel;
    logic            op_mode, op_carry;
    logic [ID_W-1:0] op_id;

    logic [15:0]     alu_result;
    logic            alu_carry;
    logic [15:0]     res_q;
    logic            carry_q;
    logic [ID_W-1:0] id_q;

    // Round-robin search starting just after the last accepted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Gated by rst_n so no grant is visible while reset is held.
    assign accept        = rst_n && (state == IDLE) && grant_found;
    assign bus.req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = EXEC;
            EXEC:    next_state = RESP;
            RESP:    if (bus.rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the winner's operation and remember it for round-robin order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            op_sel     <= '0;
            op_mode    <= 1'b0;
            op_carry   <= 1'b0;
            op_id      <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            op_a       <= bus.req_a[{grant_idx, 4'b0000} +: 16];
            op_b       <= bus.req_b[{grant_idx, 4'b0000} +: 16];
            op_sel     <= bus.req_select[{grant_idx, 2'b00} +: 4];
            op_mode    <= bus.req_mode[grant_idx];
            op_carry   <= bus.req_carry[grant_idx];
            op_id      <= grant_idx;
            last_grant <= grant_idx;
        end
    end

    alu_arbiter_alu alu (
        .a         (op_a),
        .b         (op_b),
        .sel       (op_sel),
        .mode      (op_mode),
        .carry_in  (op_carry),
        .result    (alu_result),
        .carry_out (alu_carry)
    );

    // Register the ALU output in EXEC; it then holds through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= '0;
        end else if (state == EXEC) begin
            res_q   <= alu_result;
            carry_q <= alu_carry;
            id_q    <= op_id;
        end
    end

    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_carry  = carry_q;
    assign dbg_state      = state;
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the ALU; legal range 2..8.
REQ-002 Parameter ID_W, default 2, requester id width, equal to clog2(NUM_REQ).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_a, req_b  input  16*NUM_REQ each  packed operands, requester i at bits [16i+15:16i].
REQ-008 req_select  input  4*NUM_REQ  packed ALU function select.
REQ-009 req_mode  input  NUM_REQ  per-requester mode: 1 = logic, 0 = arithmetic.
REQ-010 req_carry  input  NUM_REQ  per-requester carry_in.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_ready  input  1  consumer accepts result.
REQ-013 rsp_id  output  ID_W  index of the requester that owns the result.
REQ-014 rsp_result  output  16  ALU result.
REQ-015 rsp_carry  output  1  ALU carry_out; 0 for logic-mode operations.

Function
REQ-016 FSM states SHALL be IDLE, EXEC and RESP.
REQ-017 IDLE: if any req_valid is high, grant the winner, assert its req_ready combinationally in that cycle, capture its operands/select/mode/carry into operand registers, go to EXEC; else stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: search starts at index (last_grant+1) mod NUM_REQ and wraps; last_grant resets to NUM_REQ-1, so requester 0 has first priority.
REQ-019 last_grant SHALL update only on an accepted request.
REQ-020 EXEC: registered operands drive the ALU for one cycle; result and carry are registered; go to RESP.
REQ-021 RESP: rsp_valid high with stable rsp_id/rsp_result/rsp_carry until the rsp_valid&&rsp_ready cycle, then go to IDLE.
REQ-022 Latency: accept at cycle N gives rsp_valid at N+2; with rsp_ready tied high, a new accept is possible at N+3 at the earliest (throughput 1 op per 3 cycles).
REQ-023 req_ready SHALL be 0 in EXEC and RESP; requests arriving then are held off, never dropped or reordered.
REQ-024 A requester dropping req_valid without an accept SHALL have no effect; a request raised in the same cycle as another wins only by round-robin order.
REQ-025 Arithmetic results SHALL be 17-bit, carry_out = bit 16; subtraction forms wrap modulo 2^16 with carry_out = borrow bit.

Reset
REQ-026 On rst_n low, immediately: state IDLE, req_ready 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_carry 0, last_grant NUM_REQ-1, operand registers 0.
REQ-027 Reset in EXEC or RESP SHALL discard the in-flight operation with no response emitted.
REQ-028 The first accept SHALL occur no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the mode encodings (MODE_LOGIC=1, MODE_ARITH=0) and the 4-bit select constants.
REQ-030 The ALU datapath SHALL be a single sub-module instance, alu, fed only from the operand registers.
REQ-031 The round-robin search SHALL be a combinational function of req_valid and last_grant.

Verification
REQ-032 Single request: req_valid[1], mode 0, select 1001, A=0xFFFF, B=0x0001, carry 0 -> rsp_valid two cycles later, rsp_id 1, rsp_result 0x0000, rsp_carry 1.
REQ-033 All four request continuously after reset, rsp_ready high -> grant order 0,1,2,3,0, one accept every 3 cycles.
REQ-034 Backpressure: rsp_ready low for 5 cycles in RESP -> rsp outputs stable, req_ready stays 0; accept occurs on the cycle after the handshake.
REQ-035 Logic op: mode 1, select 0110, A=0x00FF, B=0x0F0F -> rsp_result 0x0FF0, rsp_carry 0.
REQ-036 Reset asserted in EXEC -> rsp_valid never rises for that operation; after release requester 0 wins first.
